// File: rtl/sdc_card_cmd_resp.sv
// Card-side SD CMD line endpoint: receives 48-bit host commands and serialises R1/R3/R6/R7/R2 responses.
// Optional macro SDC_CARD_CRC_CHK_EN enables CRC7 checking of received commands.
module sdc_card_cmd_resp #(
    parameter int NCR     = 2,
    parameter int RESP_TO = 64
) (
    input  logic         sd_clk,
    input  logic         reset,
    input  logic         cmd_in,
    output logic         cmd_out,
    output logic         cmd_oe,
    output logic         cmd_strb,
    output logic [5:0]   cmd_index,
    output logic [31:0]  cmd_arg,
    output logic         cmd_crc_err,
    output logic         resp_ready,
    input  logic         resp_req,
    input  logic [1:0]   resp_type,
    input  logic [5:0]   resp_index,
    input  logic [31:0]  resp_arg,
    input  logic [119:0] resp_r2_data,
    output logic         resp_busy
);
    localparam int CNT_MAX = (RESP_TO > NCR) ? RESP_TO : NCR;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RX        = 3'd1,
        CHK       = 3'd2,
        WAIT_RESP = 3'd3,
        NCR_WAIT  = 3'd4,
        TX        = 3'd5
    } state_t;

    // CRC7 (x^7+x^3+1, init 0); leading zero bits leave the result unchanged
    function automatic logic [6:0] crc7(input logic [119:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = 119; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    // Response frame, left-aligned in 136 bits
    function automatic logic [135:0] build_frame(input logic [1:0] t, input logic [5:0] idx,
                                                 input logic [31:0] arg, input logic [119:0] r2);
        logic [39:0]  head;
        logic [135:0] f;
        head = {2'b00, idx, arg};
        case (t)
            2'b01:   f = {head, crc7({80'd0, head}), 1'b1, 88'd0};
            2'b10:   f = {2'b00, 6'h3F, arg, 7'h7F, 1'b1, 88'd0};
            2'b11:   f = {2'b00, 6'h3F, r2, crc7(r2), 1'b1};
            default: f = {136{1'b1}};
        endcase
        return f;
    endfunction

    state_t           state_r, state_next;
    logic             prev_zero_r;
    logic [37:0]      rx_sr_r;
    logic [7:0]       bit_cnt_r;
    logic [CNT_W-1:0] end_cnt_r;
    logic [135:0]     tx_sr_r;
    logic [7:0]       tx_len_r;
    logic             cmd_out_r, cmd_oe_r, cmd_strb_r, cmd_crc_err_r, resp_ready_r, resp_busy_r;
    logic [5:0]       cmd_index_r;
    logic [31:0]      cmd_arg_r;
    logic             rx_ok_s, rx_bad_s, ncr_done_s, to_done_s, resp_go_s, start_tx_s;
    logic [135:0]     new_frame_s, tx_src_s;

`ifdef SDC_CARD_CRC_CHK_EN
    logic [6:0] rx_crc_r;

    // Captures the received CRC7 field (frame bits 7..1)
    always_ff @(posedge sd_clk) begin
        if (reset) begin
            rx_crc_r <= 7'd0;
        end else if ((state_r == RX) && (bit_cnt_r >= 8'd40)) begin
            rx_crc_r <= {rx_crc_r[5:0], cmd_in};
        end else begin
            rx_crc_r <= rx_crc_r;
        end
    end

    // Start and direction bits are always 0,1 once RX has been entered
    assign rx_ok_s  = cmd_in && (crc7({80'd0, 2'b01, rx_sr_r}) == rx_crc_r);
    assign rx_bad_s = ~rx_ok_s;
`else
    assign rx_ok_s  = cmd_in;
    assign rx_bad_s = 1'b0;
`endif

    assign resp_go_s   = resp_req && (resp_type != 2'b00);
    assign ncr_done_s  = (end_cnt_r >= CNT_W'(NCR - 1));
    assign to_done_s   = (end_cnt_r >= CNT_W'(RESP_TO));
    assign new_frame_s = build_frame(resp_type, resp_index, resp_arg, resp_r2_data);
    assign tx_src_s    = (state_r == NCR_WAIT) ? tx_sr_r : new_frame_s;
    assign start_tx_s  = (state_next == TX) && (state_r != TX);

    // State register
    always_ff @(posedge sd_clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_r;
        case (state_r)
            IDLE: begin
                if (prev_zero_r && cmd_in) state_next = RX;
                else                       state_next = IDLE;
            end
            RX: begin
                if (bit_cnt_r == 8'd47) state_next = CHK;
                else                    state_next = RX;
            end
            CHK: begin
                if (cmd_strb_r) state_next = WAIT_RESP;
                else            state_next = IDLE;
            end
            WAIT_RESP: begin
                if (resp_go_s)                  state_next = ncr_done_s ? TX : NCR_WAIT;
                else if (resp_req || to_done_s) state_next = IDLE;
                else                            state_next = WAIT_RESP;
            end
            NCR_WAIT: begin
                if (ncr_done_s) state_next = TX;
                else            state_next = NCR_WAIT;
            end
            TX: begin
                if (bit_cnt_r == tx_len_r) state_next = IDLE;
                else                       state_next = TX;
            end
            default: state_next = IDLE;
        endcase
    end

    // Receive shifter, response loader/serialiser and registered outputs
    always_ff @(posedge sd_clk) begin
        if (reset) begin
            prev_zero_r   <= 1'b0;
            rx_sr_r       <= 38'd0;
            bit_cnt_r     <= 8'd0;
            end_cnt_r     <= '0;
            tx_sr_r       <= {136{1'b1}};
            tx_len_r      <= 8'd48;
            cmd_out_r     <= 1'b1;
            cmd_oe_r      <= 1'b0;
            cmd_strb_r    <= 1'b0;
            cmd_crc_err_r <= 1'b0;
            cmd_index_r   <= 6'd0;
            cmd_arg_r     <= 32'd0;
            resp_ready_r  <= 1'b0;
            resp_busy_r   <= 1'b0;
        end else begin
            cmd_strb_r    <= 1'b0;
            cmd_crc_err_r <= 1'b0;
            resp_ready_r  <= (state_next == WAIT_RESP);
            prev_zero_r   <= (state_r == IDLE) ? ~cmd_in : 1'b0;
            if (end_cnt_r < CNT_W'(CNT_MAX)) end_cnt_r <= end_cnt_r + CNT_W'(1);
            case (state_r)
                IDLE: begin
                    bit_cnt_r <= 8'd2;
                end
                RX: begin
                    bit_cnt_r <= bit_cnt_r + 8'd1;
                    // Only index and argument are kept; shifting stops after frame bit 8
                    if (bit_cnt_r < 8'd40) rx_sr_r <= {rx_sr_r[36:0], cmd_in};
                    if (bit_cnt_r == 8'd47) begin
                        end_cnt_r     <= CNT_W'(1);
                        cmd_strb_r    <= rx_ok_s;
                        cmd_crc_err_r <= rx_bad_s;
                        if (rx_ok_s) begin
                            cmd_index_r <= rx_sr_r[37:32];
                            cmd_arg_r   <= rx_sr_r[31:0];
                        end
                    end
                end
                WAIT_RESP: begin
                    if (resp_go_s) begin
                        tx_sr_r     <= new_frame_s;
                        tx_len_r    <= (resp_type == 2'b11) ? 8'd136 : 8'd48;
                        resp_busy_r <= 1'b1;
                    end
                end
                TX: begin
                    if (bit_cnt_r == tx_len_r) begin
                        cmd_oe_r    <= 1'b0;
                        cmd_out_r   <= 1'b1;
                        resp_busy_r <= 1'b0;
                    end else begin
                        cmd_out_r <= tx_sr_r[135];
                        tx_sr_r   <= {tx_sr_r[134:0], 1'b1};
                        bit_cnt_r <= bit_cnt_r + 8'd1;
                    end
                end
                default: begin
                end
            endcase
            // Start bit goes out on the first TX cycle
            if (start_tx_s) begin
                cmd_oe_r  <= 1'b1;
                cmd_out_r <= tx_src_s[135];
                tx_sr_r   <= {tx_src_s[134:0], 1'b1};
                bit_cnt_r <= 8'd1;
            end
        end
    end

    assign cmd_out     = cmd_out_r;
    assign cmd_oe      = cmd_oe_r;
    assign cmd_strb    = cmd_strb_r;
    assign cmd_index   = cmd_index_r;
    assign cmd_arg     = cmd_arg_r;
    assign cmd_crc_err = cmd_crc_err_r;
    assign resp_ready  = resp_ready_r;
    assign resp_busy   = resp_busy_r;
endmodule

// File: tb/tb_sdc_card_cmd_resp.sv
// Randomised self-checking bench for sdc_card_cmd_resp against a transaction-level reference model.
`timescale 1ns/1ps
module tb_sdc_card_cmd_resp;
    localparam int NCR     = 4;
    localparam int RESP_TO = 24;
    typedef logic [135:0] v_t;

    logic         sd_clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_in = 1'b1;
    logic         cmd_out, cmd_oe, cmd_strb, cmd_crc_err, resp_ready, resp_busy;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_arg;
    logic         resp_req = 1'b0;
    logic [1:0]   resp_type = 2'b00;
    logic [5:0]   resp_index = 6'd0;
    logic [31:0]  resp_arg = 32'd0;
    logic [119:0] resp_r2_data = 120'd0;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [5:0]  last_idx = 6'd0;
    logic [31:0] last_arg = 32'd0;
    v_t          last_bits;

    sdc_card_cmd_resp #(.NCR(NCR), .RESP_TO(RESP_TO)) dut (
        .sd_clk(sd_clk), .reset(reset), .cmd_in(cmd_in), .cmd_out(cmd_out), .cmd_oe(cmd_oe),
        .cmd_strb(cmd_strb), .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_crc_err(cmd_crc_err),
        .resp_ready(resp_ready), .resp_req(resp_req), .resp_type(resp_type), .resp_index(resp_index),
        .resp_arg(resp_arg), .resp_r2_data(resp_r2_data), .resp_busy(resp_busy)
    );

    always #5 sd_clk = ~sd_clk;
    always @(posedge sd_clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge sd_clk);
        #1;
    endtask

    task automatic check(input string tag, input v_t obs, input v_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic rbit();
        logic [31:0] r;
        r = $urandom;
        return r[0];
    endfunction

    // Remainder of msg(x)*x^7 divided by x^7+x^3+1, by long division
    function automatic logic [6:0] ref_crc7(input logic [119:0] msg, input int nbits);
        logic [126:0] r;
        r = {msg, 7'd0};
        for (int i = nbits + 6; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] make_cmd(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b01, idx, arg, ref_crc7({80'd0, 2'b01, idx, arg}, 40), 1'b1};
    endfunction

    task automatic send_frame(input logic [47:0] f, output int t0);
        repeat (2) tick();
        for (int i = 47; i >= 0; i--) begin
            cmd_in = f[i];
            if (i == 0) t0 = cyc;
            tick();
        end
        cmd_in = 1'b1;
    endtask

    // One command plus the card's reaction; delay < 0 means never request a response
    task automatic transact(input logic [47:0] f, input logic [1:0] rtype, input logic [5:0] ridx,
                            input logic [31:0] rarg, input logic [119:0] r2, input int delay);
        int t0, a, n, exp_start, exp_len, len;
        logic exp_strb, exp_err, oe_seen, ready_drop, busy_bad, strb_seen;
        v_t exp_bits, bits;
        send_frame(f, t0);
`ifdef SDC_CARD_CRC_CHK_EN
        exp_strb = f[0] && (ref_crc7({80'd0, f[47:8]}, 40) == f[7:1]);
        exp_err  = !exp_strb;
`else
        exp_strb = f[0];
        exp_err  = 1'b0;
`endif
        check("cmd_strb", v_t'(cmd_strb), v_t'(exp_strb));
        check("cmd_crc_err", v_t'(cmd_crc_err), v_t'(exp_err));
        if (exp_strb) begin
            last_idx = f[45:40];
            last_arg = f[39:8];
        end
        check("cmd_index", v_t'(cmd_index), v_t'(last_idx));
        check("cmd_arg", v_t'(cmd_arg), v_t'(last_arg));
        tick();
        check("strb_one_cycle", v_t'(cmd_strb | cmd_crc_err), v_t'(0));
        check("resp_ready_after_chk", v_t'(resp_ready), v_t'(exp_strb));
        if (!exp_strb) return;

        if (delay < 0) begin
            oe_seen = 1'b0;
            ready_drop = 1'b0;
            while (cyc < t0 + RESP_TO) begin
                oe_seen |= cmd_oe;
                ready_drop |= !resp_ready;
                cmd_in = rbit();
                tick();
            end
            check("ready_until_timeout", v_t'(resp_ready & !ready_drop), v_t'(1));
            cmd_in = 1'b1;
            tick();
            check("ready_after_timeout", v_t'(resp_ready), v_t'(0));
            check("no_oe_on_timeout", v_t'(oe_seen | cmd_oe), v_t'(0));
            return;
        end

        ready_drop = 1'b0;
        repeat (delay) begin
            ready_drop |= !resp_ready;
            cmd_in = rbit();
            tick();
        end
        check("ready_at_req", v_t'(resp_ready & !ready_drop), v_t'(1));
        a = cyc;
        resp_req = 1'b1;
        resp_type = rtype;
        resp_index = ridx;
        resp_arg = rarg;
        resp_r2_data = r2;
        cmd_in = rbit();
        tick();
        // Scramble the request inputs so the response must come from latched values
        resp_req = 1'b0;
        resp_type = 2'($urandom);
        resp_index = 6'($urandom);
        resp_arg = $urandom;
        resp_r2_data = {24'($urandom), $urandom, $urandom, $urandom};

        if (rtype == 2'b00) begin
            cmd_in = 1'b1;
            check("drop_ready", v_t'(resp_ready), v_t'(0));
            check("drop_busy", v_t'(resp_busy), v_t'(0));
            oe_seen = 1'b0;
            repeat (6) begin
                oe_seen |= cmd_oe;
                tick();
            end
            check("drop_no_oe", v_t'(oe_seen), v_t'(0));
            return;
        end

        case (rtype)
            2'b01: begin
                exp_bits = {88'd0, 2'b00, ridx, rarg, ref_crc7({80'd0, 2'b00, ridx, rarg}, 40), 1'b1};
                exp_len = 48;
            end
            2'b10: begin
                exp_bits = {88'd0, 2'b00, 6'h3F, rarg, 7'h7F, 1'b1};
                exp_len = 48;
            end
            default: begin
                exp_bits = {2'b00, 6'h3F, r2, ref_crc7(r2, 120), 1'b1};
                exp_len = 136;
            end
        endcase
        exp_start = (t0 + NCR > a + 1) ? t0 + NCR : a + 1;
        check("busy_after_accept", v_t'(resp_busy), v_t'(1));
        n = 0;
        while (!cmd_oe && n < 100) begin
            cmd_in = rbit();
            tick();
            n++;
        end
        check("resp_start_cycle", v_t'(cyc), v_t'(exp_start));
        bits = '0;
        len = 0;
        busy_bad = 1'b0;
        strb_seen = 1'b0;
        while (cmd_oe && len < 200) begin
            bits = {bits[134:0], cmd_out};
            len++;
            busy_bad |= !resp_busy;
            strb_seen |= cmd_strb;
            cmd_in = rbit();
            tick();
        end
        cmd_in = 1'b1;
        last_bits = bits;
        check("resp_len", v_t'(len), v_t'(exp_len));
        check("resp_bits", bits, exp_bits);
        check("busy_during_tx", v_t'(busy_bad | strb_seen), v_t'(0));
        check("line_idle_after_tx", v_t'({cmd_out, resp_busy}), v_t'(2'b10));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, n;
        logic [5:0]  ridx;
        logic [31:0] rarg;
        logic [47:0] f;
        int kind, delay;

        repeat (3) tick();
        check("rst_cmd_out", v_t'(cmd_out), v_t'(1));
        check("rst_cmd_oe", v_t'(cmd_oe), v_t'(0));
        check("rst_pulses", v_t'({cmd_strb, cmd_crc_err}), v_t'(0));
        check("rst_fields", v_t'({cmd_index, cmd_arg}), v_t'(0));
        check("rst_resp", v_t'({resp_ready, resp_busy}), v_t'(0));
        reset = 1'b0;
        tick();

        // CMD0, never answered
        transact(48'h400000000095, 2'b00, 6'd0, 32'd0, 120'd0, -1);
        // CMD8 answered by R7 immediately
        transact(48'h48000001AA87, 2'b01, 6'd8, 32'h000001AA, 120'd0, 0);
        check("cmd8_resp_literal", last_bits, v_t'(48'h08000001AA13));
        // ACMD41 answered by R3
        transact(make_cmd(6'd41, 32'h40FF8000), 2'b10, 6'd0, 32'h80FF8000, 120'd0, 3);
        check("r3_resp_literal", last_bits, v_t'(48'h3F80FF8000FF));
        // Bad CRC; accepted only when receive checking is absent
        transact(48'h400000000097, 2'b00, 6'd0, 32'd0, 120'd0, 1);
        // R2 with all-zero payload
        transact(make_cmd(6'd2, 32'd0), 2'b11, 6'd0, 32'd0, 120'd0, 5);
        check("r2_zero_literal", last_bits, {8'h3F, 120'd0, 7'h00, 1'b1});

        // Reset while bit 20 of an R1 is on the line
        send_frame(make_cmd(6'd13, 32'h12340000), t0);
        tick();
        resp_req = 1'b1;
        resp_type = 2'b01;
        resp_index = 6'd13;
        resp_arg = 32'hDEADBEEF;
        tick();
        resp_req = 1'b0;
        n = 0;
        while (!cmd_oe && n < 100) begin
            tick();
            n++;
        end
        repeat (20) tick();
        check("oe_before_reset", v_t'(cmd_oe), v_t'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midtx_reset_line", v_t'({cmd_oe, cmd_out, resp_busy, resp_ready}), v_t'(4'b0100));
        check("midtx_reset_fields", v_t'({cmd_index, cmd_arg}), v_t'(0));
        last_idx = 6'd0;
        last_arg = 32'd0;
        transact(48'h400000000095, 2'b00, 6'd0, 32'd0, 120'd0, -1);

        for (int k = 0; k < 12; k++) begin
            f = make_cmd(6'($urandom), $urandom);
            kind = $urandom_range(0, 3);
            if (kind == 2) f[3] = ~f[3];
            if (kind == 3) f[0] = 1'b0;
            delay = $urandom_range(0, RESP_TO - 2);
            if (k % 4 == 3) delay = -1;
            ridx = 6'($urandom);
            rarg = $urandom;
            transact(f, 2'($urandom), ridx, rarg, {24'($urandom), $urandom, $urandom, $urandom}, delay);
        end

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
